// File: rtl/fetch_pkg.sv
// Shared constants and state encoding for the fetch path; the instruction
// memory and decode blocks import ADDR_W/DATA_W from here as well.
package fetch_pkg;
  localparam int          ADDR_W    = 6;
  localparam int          DATA_W    = 32;
  localparam int          CNT_W     = 16;
  localparam logic [5:0]  RESET_PC  = 6'd0;
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
module fetch_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);
  always_ff @(posedge clk) begin
    if (!clr_n)                count <= '0;
    else if (en && count != '1) count <= count + CNT_W'(1);
  end
endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter, one-entry fetch register and valid/ready hand-off to decode,
// with branch redirect, halt detection and an accepted-instruction counter.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W    = fetch_pkg::ADDR_W,
  parameter int                DATA_W    = fetch_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC  = fetch_pkg::RESET_PC,
  parameter logic [DATA_W-1:0] HALT_WORD = fetch_pkg::HALT_WORD,
  parameter int                CNT_W     = fetch_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_target,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              halted,
  output logic [CNT_W-1:0]  fetch_count
);
  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc;
  logic              acc, slot_free, load, is_halt;

  assign imem_addr = pc;
  assign acc       = if_valid && if_ready;
  assign slot_free = !if_valid || acc;
  assign is_halt   = (imem_data == HALT_WORD);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (!br_valid && load && is_halt) state_nxt = HALT;
      HALT:    if (br_valid) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // A redirect always wins over a load in the same cycle.
  always_comb begin
    load = (state == FETCH) && slot_free && !br_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
      halted   <= 1'b0;
    end else if (br_valid) begin
      pc       <= br_target;
      if_valid <= 1'b0;
      halted   <= 1'b0;
    end else if (load) begin
      if_instr <= imem_data;
      if_pc    <= pc;
      if_valid <= 1'b1;
      pc       <= pc + ADDR_W'(1);
      if (is_halt) halted <= 1'b1;
    end else if (acc) begin
      if_valid <= 1'b0;
    end
  end

  fetch_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .clr_n (rst_n),
    .en    (acc),
    .count (fetch_count)
  );
endmodule
